// File: rtl/pixel_pkg.sv
// Shared types and sizing helpers for the pixel collector and its frame counter.
package pixel_pkg;

  typedef enum logic [1:0] {WAIT, SEND, CLR} state_t;

  localparam int DATA_W_DEF = 24;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_frame_counter.sv
// Raster position tracker: x/y counters stepped by 'advance', with line/frame markers.
module pixel_frame_counter
  import pixel_pkg::*;
#(
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic aclk,
  input  logic clr,
  input  logic advance,
  output logic sol,
  output logic eol,
  output logic sof,
  output logic frame_end
);

  localparam int XW = idx_w(X_SIZE);
  localparam int YW = idx_w(Y_SIZE);
  localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

  logic [XW-1:0] x;
  logic [YW-1:0] y;

  // NOTE: state registers use <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (clr) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  assign sol       = (x == '0);
  assign eol       = (x == X_LAST);
  assign sof       = sol && (y == '0);
  assign frame_end = eol && (y == Y_LAST);

endmodule

// File: rtl/pixel_collector.sv
// Round-robin reader of per-lane result buffers onto an AXI4-Stream video port.
// Define PIXEL_SKID_EN to release each lane as soon as its pixel is captured.
module pixel_collector
  import pixel_pkg::*;
#(
  parameter int LANES  = 4,
  parameter int DATA_W = DATA_W_DEF,
  parameter int X_SIZE = 640,
  parameter int Y_SIZE = 480
) (
  input  logic                    aclk,
  input  logic                    clr,
  input  logic [LANES-1:0]        lane_flag,
  input  logic [LANES*DATA_W-1:0] lane_rgb,
  output logic [LANES-1:0]        lane_clr,
  output logic [DATA_W-1:0]       m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tuser,
  output logic                    frame_done
);

  localparam int LW = idx_w(LANES);
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

  state_t          state, state_nx;
  logic [LW-1:0]   lane_idx;
  logic [LANES-1:0] lane_hot;
  logic            take, xfer, advance;
  logic            sol, eol, sof, frame_end;
`ifdef PIXEL_SKID_EN
  logic            hold_end;
`endif

  pixel_frame_counter #(
    .X_SIZE(X_SIZE),
    .Y_SIZE(Y_SIZE)
  ) u_frame (
    .aclk      (aclk),
    .clr       (clr),
    .advance   (advance),
    .sol       (sol),
    .eol       (eol),
    .sof       (sof),
    .frame_end (frame_end)
  );

  assign lane_hot = LANES'(1) << lane_idx;

  always_ff @(posedge aclk) begin
    if (clr) state <= WAIT;
    else     state <= state_nx;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    xfer     = 1'b0;
    advance  = 1'b0;
`ifdef PIXEL_SKID_EN
    xfer = m_axis_tvalid && m_axis_tready;
    unique case (state)
      WAIT: if (lane_flag[lane_idx] && !m_axis_tvalid) begin
        take     = 1'b1;
        advance  = 1'b1;
        state_nx = CLR;
      end
      default: state_nx = WAIT;
    endcase
`else
    unique case (state)
      WAIT: if (lane_flag[lane_idx]) begin
        take     = 1'b1;
        state_nx = SEND;
      end
      SEND: if (m_axis_tready) begin
        xfer     = 1'b1;
        state_nx = CLR;
      end
      CLR: begin
        advance  = 1'b1;
        state_nx = WAIT;
      end
      default: state_nx = WAIT;
    endcase
`endif
  end

  always_ff @(posedge aclk) begin
    if (clr) begin
      lane_idx      <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      lane_clr      <= '0;
      frame_done    <= 1'b0;
`ifdef PIXEL_SKID_EN
      hold_end      <= 1'b0;
`endif
    end else begin
      lane_clr   <= '0;
      frame_done <= 1'b0;
      if (take) begin
        m_axis_tdata  <= lane_rgb[lane_idx*DATA_W +: DATA_W];
        m_axis_tlast  <= eol;
        m_axis_tuser  <= sof;
        m_axis_tvalid <= 1'b1;
      end else if (xfer) begin
        m_axis_tvalid <= 1'b0;
      end
      if (advance) lane_idx <= (lane_idx == LANE_LAST) ? '0 : lane_idx + 1'b1;
`ifdef PIXEL_SKID_EN
      // The lane is released at capture; frame_done waits for the held pixel to leave.
      if (take) begin
        lane_clr <= lane_hot;
        hold_end <= frame_end;
      end
      if (xfer) frame_done <= hold_end;
`else
      if (xfer) begin
        lane_clr   <= lane_hot;
        frame_done <= frame_end;
      end
`endif
    end
  end

  a_lane_clr_onehot: assert property (@(posedge aclk) disable iff (clr) $onehot0(lane_clr));
  a_sof_at_line_start: assert property (@(posedge aclk) disable iff (clr) sof |-> sol);

endmodule

// File: tb/tb_pixel_collector.sv
// Bench for pixel_collector: 4-lane and 1-lane instances on a 4x2 raster, checked against a raster model.
module tb_pixel_collector;

  localparam int L4 = 4;
  localparam int DW = 24;
  localparam int XS = 4;
  localparam int YS = 2;
`ifdef PIXEL_SKID_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 3;
`endif

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
    logic          user;
    int            cyc;
  } beat_t;

  logic             aclk, clr, tready;
  logic [L4-1:0]    flag4, lclr4;
  logic [L4*DW-1:0] rgb4;
  logic [DW-1:0]    tdata4;
  logic             tvalid4, tlast4, tuser4, fd4;
  logic [0:0]       flag1, lclr1;
  logic [DW-1:0]    rgb1, tdata1;
  logic             tvalid1, tlast1, tuser1, fd1;

  pixel_collector #(.LANES(L4), .DATA_W(DW), .X_SIZE(XS), .Y_SIZE(YS)) dut4 (
    .aclk(aclk), .clr(clr), .lane_flag(flag4), .lane_rgb(rgb4), .lane_clr(lclr4),
    .m_axis_tdata(tdata4), .m_axis_tvalid(tvalid4), .m_axis_tready(tready),
    .m_axis_tlast(tlast4), .m_axis_tuser(tuser4), .frame_done(fd4)
  );

  pixel_collector #(.LANES(1), .DATA_W(DW), .X_SIZE(XS), .Y_SIZE(YS)) dut1 (
    .aclk(aclk), .clr(clr), .lane_flag(flag1), .lane_rgb(rgb1), .lane_clr(lclr1),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1), .m_axis_tready(tready),
    .m_axis_tlast(tlast1), .m_axis_tuser(tuser1), .frame_done(fd1)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Observed traffic
  beat_t      beats4[$];
  beat_t      beats1[$];
  logic [3:0] clr_log4[$];
  int         fd_cyc4[$];
  int         clr_cnt1 = 0;
  int         fd_cnt1 = 0;
  int         multi_hot = 0;

  // Reference model: per-lane FIFOs of loaded values plus raster position by pixel number
  logic [DW-1:0] lane_q4 [L4][$];
  logic [DW-1:0] lane_q1 [$];
  int pix4 = 0, ld4 = 0, pix1 = 0;

  function automatic beat_t model_next4();
    beat_t b;
    int k, x, y;
    k = pix4 % L4;
    x = pix4 % XS;
    y = (pix4 / XS) % YS;
    b.data = '0;
    if (lane_q4[k].size() > 0) b.data = lane_q4[k].pop_front();
    b.last = (x == XS - 1);
    b.user = (x == 0) && (y == 0);
    b.cyc  = 0;
    pix4++;
    return b;
  endfunction

  function automatic beat_t model_next1();
    beat_t b;
    int x, y;
    x = pix1 % XS;
    y = (pix1 / XS) % YS;
    b.data = '0;
    if (lane_q1.size() > 0) b.data = lane_q1.pop_front();
    b.last = (x == XS - 1);
    b.user = (x == 0) && (y == 0);
    b.cyc  = 0;
    pix1++;
    return b;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < L4; k++) lane_q4[k].delete();
    lane_q1.delete();
    pix4 = 0;
    ld4  = 0;
    pix1 = 0;
  endtask

  task automatic log_reset();
    beats4.delete();
    beats1.delete();
    clr_log4.delete();
    fd_cyc4.delete();
    clr_cnt1 = 0;
    fd_cnt1  = 0;
  endtask

  task automatic hit4(input int k, input logic [DW-1:0] v);
    flag4[k]          = 1'b1;
    rgb4[k*DW +: DW]  = v;
    lane_q4[k].push_back(v);
    ld4++;
  endtask

  task automatic hit1(input logic [DW-1:0] v);
    flag1[0] = 1'b1;
    rgb1     = v;
    lane_q1.push_back(v);
  endtask

  // One clock: sample outputs before the edge, then let the lane buffers react to clears.
  task automatic tick();
    beat_t      b;
    logic [3:0] lc4;
    logic       lc1, c;
    if (tvalid4 && tready) begin
      b.data = tdata4; b.last = tlast4; b.user = tuser4; b.cyc = cyc;
      beats4.push_back(b);
    end
    if (tvalid1 && tready) begin
      b.data = tdata1; b.last = tlast1; b.user = tuser1; b.cyc = cyc;
      beats1.push_back(b);
    end
    if (lclr4 != '0) clr_log4.push_back(lclr4);
    if (!$onehot0(lclr4)) multi_hot++;
    if (fd4) fd_cyc4.push_back(cyc);
    if (lclr1[0]) clr_cnt1++;
    if (fd1) fd_cnt1++;
    lc4 = lclr4;
    lc1 = lclr1[0];
    c   = clr;
    @(posedge aclk);
    #1;
    cyc++;
    for (int k = 0; k < L4; k++) if (c || lc4[k]) flag4[k] = 1'b0;
    if (c || lc1) flag1[0] = 1'b0;
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    model_reset();
    log_reset();
  endtask

  task automatic wait_beats4(input int n, input int budget, output bit ok);
    for (int i = 0; i < budget && beats4.size() < n; i++) tick();
    ok = (beats4.size() >= n);
  endtask

  // Loads n pixels into the 4-lane buffers in pixel order whenever the owning lane is free.
  task automatic feed4(input int n, input int budget, input bit rnd, output bit ok);
    int ld = 0;
    int start = beats4.size();
    for (int i = 0; i < budget; i++) begin
      if (ld < n && !flag4[ld4 % L4] && (!rnd || ($urandom % 2 == 0))) begin
        hit4(ld4 % L4, DW'($urandom));
        ld++;
      end
      tready = rnd ? ($urandom % 4 != 0) : 1'b1;
      if (beats4.size() >= start + n) break;
      tick();
    end
    ok = (beats4.size() >= start + n);
  endtask

  task automatic test_reset();
    clr    = 1'b1;
    tready = 1'b0;
    tick();
    tick();
    n_checks++;
    if (tdata4 !== '0 || tvalid4 !== 1'b0 || tlast4 !== 1'b0 || tuser4 !== 1'b0 ||
        lclr4 !== '0 || fd4 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs4: tdata=%h tvalid=%b tlast=%b tuser=%b lane_clr=%b fd=%b, all must be 0",
               tdata4, tvalid4, tlast4, tuser4, lclr4, fd4);
    end
    n_checks++;
    if (tdata1 !== '0 || tvalid1 !== 1'b0 || lclr1 !== '0 || fd1 !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs1: tdata=%h tvalid=%b lane_clr=%b fd=%b, all must be 0",
               tdata1, tvalid1, lclr1, fd1);
    end
    clr = 1'b0;
    model_reset();
    log_reset();
    settle(5);
    n_checks++;
    if (tvalid4 !== 1'b0 || beats4.size() != 0 || clr_log4.size() != 0) begin
      n_errors++;
      $display("FAIL idle_after_reset: tvalid=%b beats=%0d clears=%0d, need 0 0 0",
               tvalid4, beats4.size(), clr_log4.size());
    end
  endtask

  task automatic test_basic_order();
    beat_t exp;
    bit ok;
    tready = 1'b1;
    hit4(0, 24'h000001);
    tick();
    n_checks++;
    if (tvalid4 !== 1'b1 || tdata4 !== 24'h000001 || tuser4 !== 1'b1) begin
      n_errors++;
      $display("FAIL first_latency: tvalid=%b tdata=%h tuser=%b, need 1 000001 1", tvalid4, tdata4, tuser4);
    end
    hit4(1, 24'h000002);
    hit4(2, 24'h000003);
    hit4(3, 24'h000004);
    wait_beats4(4, 40, ok);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL basic_timeout: got %0d beats, need 4", beats4.size());
    end
    settle(3);
    for (int i = 0; i < 4; i++) begin
      exp = model_next4();
      n_checks++;
      if (i >= beats4.size()) begin
        n_errors++;
        $display("FAIL basic_beat%0d: missing, need data=%h", i, exp.data);
      end else if (beats4[i].data !== exp.data || beats4[i].last !== exp.last || beats4[i].user !== exp.user) begin
        n_errors++;
        $display("FAIL basic_beat%0d: got %h/last%b/user%b, need %h/last%b/user%b", i,
                 beats4[i].data, beats4[i].last, beats4[i].user, exp.data, exp.last, exp.user);
      end
    end
    n_checks++;
    if (clr_log4.size() != 4) begin
      n_errors++;
      $display("FAIL basic_clr_count: got %0d pulses, need 4", clr_log4.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (clr_log4[i] !== (4'b0001 << i)) begin
          n_errors++;
          $display("FAIL basic_clr%0d: got %b, need %b", i, clr_log4[i], 4'b0001 << i);
        end
      end
    end
    log_reset();
  endtask

  task automatic test_lane_order();
    beat_t exp;
    bit ok;
    tready = 1'b1;
    hit4(0, DW'($urandom));
    wait_beats4(1, 20, ok);
    settle(3);
    exp = model_next4();
    n_checks++;
    if (!ok || beats4[0].data !== exp.data || beats4[0].user !== exp.user) begin
      n_errors++;
      $display("FAIL order_lane0: got beats=%0d, need data %h", beats4.size(), exp.data);
    end
    log_reset();
    hit4(2, DW'($urandom));
    settle(12);
    n_checks++;
    if (beats4.size() != 0 || clr_log4.size() != 0) begin
      n_errors++;
      $display("FAIL order_early_lane2: got beats=%0d clears=%0d, need 0 0", beats4.size(), clr_log4.size());
    end
    hit4(1, DW'($urandom));
    wait_beats4(2, 30, ok);
    settle(3);
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL order_timeout: got %0d beats, need 2", beats4.size());
    end
    for (int i = 0; i < 2; i++) begin
      exp = model_next4();
      n_checks++;
      if (i >= beats4.size() || beats4[i].data !== exp.data || beats4[i].last !== exp.last ||
          beats4[i].user !== exp.user) begin
        n_errors++;
        $display("FAIL order_beat%0d: need data %h last%b user%b", i, exp.data, exp.last, exp.user);
      end
    end
    n_checks++;
    if (clr_log4.size() != 2 || clr_log4[0] !== 4'b0010 || clr_log4[1] !== 4'b0100) begin
      n_errors++;
      $display("FAIL order_clr_seq: got %0d pulses, need 0010 then 0100", clr_log4.size());
    end
  endtask

  task automatic test_full_frame();
    beat_t exp;
    bit ok;
    do_reset();
    feed4(9, 200, 1'b0, ok);
    settle(4);
    n_checks++;
    if (!ok || beats4.size() != 9) begin
      n_errors++;
      $display("FAIL frame_count: got %0d beats, need 9", beats4.size());
    end
    for (int i = 0; i < 9; i++) begin
      exp = model_next4();
      n_checks++;
      if (i >= beats4.size() || beats4[i].data !== exp.data || beats4[i].last !== exp.last ||
          beats4[i].user !== exp.user) begin
        n_errors++;
        $display("FAIL frame_beat%0d: need data %h last%b user%b", i, exp.data, exp.last, exp.user);
      end
    end
    n_checks++;
    if (fd_cyc4.size() != 1) begin
      n_errors++;
      $display("FAIL frame_done_count: got %0d pulses, need 1", fd_cyc4.size());
    end else if (beats4.size() > 7) begin
      n_checks++;
      if (fd_cyc4[0] != beats4[7].cyc + 1) begin
        n_errors++;
        $display("FAIL frame_done_time: got cycle %0d, need %0d", fd_cyc4[0], beats4[7].cyc + 1);
      end
    end
    n_checks++;
    if (beats4.size() < 9 || clr_log4.size() < 9 || beats4[8].user !== 1'b1 || clr_log4[8] !== 4'b0001) begin
      n_errors++;
      $display("FAIL frame_wrap: pixel 8 must carry tuser=1 and come from lane 0 (beats=%0d clears=%0d)",
               beats4.size(), clr_log4.size());
    end
  endtask

  task automatic test_backpressure();
    beat_t exp;
    do_reset();
    tready = 1'b0;
    hit4(0, DW'($urandom));
    tick();
    exp = model_next4();
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (tvalid4 !== 1'b1 || tdata4 !== exp.data || tlast4 !== exp.last || tuser4 !== exp.user) begin
        n_errors++;
        $display("FAIL stall_stable%0d: got v%b %h l%b u%b, need v1 %h l%b u%b", i,
                 tvalid4, tdata4, tlast4, tuser4, exp.data, exp.last, exp.user);
      end
`ifndef PIXEL_SKID_EN
      n_checks++;
      if (lclr4 !== 4'b0000) begin
        n_errors++;
        $display("FAIL stall_no_clr%0d: got lane_clr %b, need 0000", i, lclr4);
      end
`endif
      tick();
    end
    tready = 1'b1;
    tick();
`ifndef PIXEL_SKID_EN
    n_checks++;
    if (lclr4 !== 4'b0001) begin
      n_errors++;
      $display("FAIL stall_release: got lane_clr %b, need 0001", lclr4);
    end
    tick();
    n_checks++;
    if (lclr4 !== 4'b0000) begin
      n_errors++;
      $display("FAIL stall_release_pulse: got lane_clr %b, need 0000", lclr4);
    end
`endif
    settle(2);
    n_checks++;
    if (beats4.size() != 1 || clr_log4.size() != 1 || clr_log4[0] !== 4'b0001 || beats4[0].data !== exp.data) begin
      n_errors++;
      $display("FAIL stall_single: got beats=%0d clears=%0d, need 1 beat of %h and one 0001 clear",
               beats4.size(), clr_log4.size(), exp.data);
    end
  endtask

  task automatic test_reset_mid_send();
    beat_t exp;
    bit ok;
    do_reset();
    tready = 1'b0;
    hit4(0, DW'($urandom));
    tick();
    tick();
    n_checks++;
    if (tvalid4 !== 1'b1) begin
      n_errors++;
      $display("FAIL midreset_pending: got tvalid %b, need 1", tvalid4);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (tvalid4 !== 1'b0 || lclr4 !== 4'b0000) begin
      n_errors++;
      $display("FAIL midreset_drop: got tvalid=%b lane_clr=%b, need 0 0000", tvalid4, lclr4);
    end
    model_reset();
    log_reset();
    feed4(1, 30, 1'b0, ok);
    settle(3);
    exp = model_next4();
    n_checks++;
    if (!ok || beats4[0].data !== exp.data || beats4[0].user !== 1'b1 || clr_log4.size() != 1 ||
        clr_log4[0] !== 4'b0001) begin
      n_errors++;
      $display("FAIL midreset_restart: got beats=%0d clears=%0d, need lane 0 pixel %h with tuser=1",
               beats4.size(), clr_log4.size(), exp.data);
    end
  endtask

  task automatic test_random_stream();
    beat_t exp;
    bit ok;
    do_reset();
    feed4(40, 3000, 1'b1, ok);
    settle(5);
    n_checks++;
    if (!ok || beats4.size() != 40) begin
      n_errors++;
      $display("FAIL random_count: got %0d beats, need 40", beats4.size());
    end
    for (int i = 0; i < 40; i++) begin
      exp = model_next4();
      n_checks++;
      if (i >= beats4.size() || beats4[i].data !== exp.data || beats4[i].last !== exp.last ||
          beats4[i].user !== exp.user) begin
        n_errors++;
        $display("FAIL random_beat%0d: need data %h last%b user%b", i, exp.data, exp.last, exp.user);
      end
      if (i < clr_log4.size()) begin
        n_checks++;
        if (clr_log4[i] !== (4'b0001 << (i % L4))) begin
          n_errors++;
          $display("FAIL random_clr%0d: got %b, need %b", i, clr_log4[i], 4'b0001 << (i % L4));
        end
      end
    end
    n_checks++;
    if (clr_log4.size() != 40 || fd_cyc4.size() != 5) begin
      n_errors++;
      $display("FAIL random_totals: got clears=%0d frame_done=%0d, need 40 5", clr_log4.size(), fd_cyc4.size());
    end
    n_checks++;
    if (multi_hot != 0) begin
      n_errors++;
      $display("FAIL lane_clr_onehot: got %0d multi-hot cycles, need 0", multi_hot);
    end
  endtask

  task automatic test_single_lane();
    beat_t exp;
    int loaded = 0;
    do_reset();
    tready = 1'b1;
    for (int h = 0; h < 3; h++) begin
      hit1(DW'($urandom));
      for (int j = 0; j < 20 && beats1.size() < h + 1; j++) tick();
      settle(8);
      n_checks++;
      if (beats1.size() != h + 1) begin
        n_errors++;
        $display("FAIL single_no_dup%0d: got %0d beats, need %0d", h, beats1.size(), h + 1);
      end
    end
    for (int i = 0; i < 200 && beats1.size() < 9; i++) begin
      if (loaded < 6 && !flag1[0]) begin
        hit1(DW'($urandom));
        loaded++;
      end
      tick();
    end
    settle(4);
    n_checks++;
    if (beats1.size() != 9) begin
      n_errors++;
      $display("FAIL single_count: got %0d beats, need 9", beats1.size());
    end
    for (int i = 4; i < 9 && i < beats1.size(); i++) begin
      n_checks++;
      if (beats1[i].cyc - beats1[i-1].cyc != GAP) begin
        n_errors++;
        $display("FAIL single_gap%0d: got %0d cycles, need %0d", i, beats1[i].cyc - beats1[i-1].cyc, GAP);
      end
    end
    for (int i = 0; i < 9; i++) begin
      exp = model_next1();
      n_checks++;
      if (i >= beats1.size() || beats1[i].data !== exp.data || beats1[i].last !== exp.last ||
          beats1[i].user !== exp.user) begin
        n_errors++;
        $display("FAIL single_beat%0d: need data %h last%b user%b", i, exp.data, exp.last, exp.user);
      end
    end
    n_checks++;
    if (clr_cnt1 != 9 || fd_cnt1 != 1) begin
      n_errors++;
      $display("FAIL single_totals: got clears=%0d frame_done=%0d, need 9 1", clr_cnt1, fd_cnt1);
    end
  endtask

  initial begin
    clr    = 1'b1;
    tready = 1'b0;
    flag4  = '0;
    rgb4   = '0;
    flag1  = '0;
    rgb1   = '0;
    @(posedge aclk);
    #1;
    test_reset();
    test_basic_order();
    test_lane_order();
    test_full_frame();
    test_backpressure();
    test_reset_mid_send();
    test_random_stream();
    test_single_lane();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
